// File: rtl/spi_regfile_pkg.sv
// Shared frame-layout helpers for the SPI register-file peripheral.
// Bit positions are within the complete, MSB-first frame as held in the shift register.
package spi_regfile_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int DATA_LSB = 0;

  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int rw_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one SPI pin, plus a delay flop and registered edge pulses.
// The level output is the delayed copy, so it lines up in time with the edge pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      dly  <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
      rise <= sync & ~dly;
      fall <= ~sync & dly;
    end
  end

  assign level = dly;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register-file peripheral: writes commit on nCS deselect when the frame is
// exactly FRAME_W bits; reads return the addressed register on CIPO during the data phase.
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       COPI,
  input  logic                       SCLK,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [7:0]                 err_cnt
);

  localparam int FRAME_W  = frame_width(ADDR_W, DATA_W);
  localparam int CNT_W    = $clog2(FRAME_W + 2);
  localparam int RW_POS   = rw_pos(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_OVER    = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR    = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_ADDR_M1 = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NUM_REGS_V  = (ADDR_W + 1)'(NUM_REGS);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_rise, sclk_fall;
  logic copi_lvl;
  logic unused_sclk_lvl, unused_copi_rise, unused_copi_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (nCS),
    .level (ncs_lvl),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SCLK),
    .level (unused_sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (COPI),
    .level (copi_lvl),
    .rise  (unused_copi_rise),
    .fall  (unused_copi_fall)
  );

  logic [DATA_W-1:0]  bank [NUM_REGS];
  logic [FRAME_W-1:0] sr;
  logic [FRAME_W-1:0] sr_next;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rd_sr;
  logic [DATA_W-1:0]  rd_val;
  logic               active;
  logic               armed;
  logic [1:0]         warm;

  logic               frm_rw;
  logic [ADDR_W-1:0]  frm_addr;
  logic [DATA_W-1:0]  frm_data;
  logic               addr_ok;
  logic               frame_start;
  logic               frame_end;
  logic               commit;
  logic               discard;

  assign sr_next  = {sr[FRAME_W-2:0], copi_lvl};
  assign frm_rw   = sr[RW_POS];
  assign frm_addr = sr[ADDR_LSB +: ADDR_W];
  assign frm_data = sr[DATA_LSB +: DATA_W];
  assign addr_ok  = {1'b0, frm_addr} < NUM_REGS_V;

  // A frame in flight when reset releases must not start until nCS has been seen high.
  assign frame_start = ncs_fall && armed;
  assign frame_end   = ncs_rise && active;
  assign commit      = frame_end && (cnt == CNT_FULL) && (frm_rw == RW_WRITE) && addr_ok;
  assign discard     = frame_end && (cnt != CNT_FULL);

  // Read data is looked up from the address as it completes, i.e. from the next shift value.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sr_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = bank[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frm_addr == ADDR_W'(i)) bank[i] <= frm_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active    <= 1'b0;
      armed     <= 1'b0;
      warm      <= 2'd3;
      cnt       <= '0;
      sr        <= '0;
      rd_sr     <= '0;
      cipo_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_cnt   <= '0;
    end else begin
      wr_strobe <= commit;
      if (commit) wr_addr <= frm_addr;
      if (discard && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (warm != 2'd0) warm <= warm - 2'd1;
      else if (ncs_lvl) armed <= 1'b1;

      if (frame_start) begin
        active  <= 1'b1;
        cnt     <= '0;
        sr      <= '0;
        rd_sr   <= '0;
        cipo_oe <= 1'b0;
      end else if (frame_end) begin
        active  <= 1'b0;
        rd_sr   <= '0;
        cipo_oe <= 1'b0;
      end else if (active && sclk_rise) begin
        if (cnt < CNT_FULL) begin
          sr  <= sr_next;
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_ADDR_M1 && sr_next[ADDR_W] == RW_READ) begin
            rd_sr   <= rd_val;
            cipo_oe <= 1'b1;
          end
        end else if (cnt != CNT_OVER) begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (active && sclk_fall && cipo_oe && cnt > CNT_ADDR) begin
        // The fall right after the address keeps the MSB up for the first data rise.
        rd_sr <= rd_sr << 1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = bank[g];
  end

  assign CIPO = rd_sr[DATA_W-1];

endmodule

// File: doc/spi_regfile_periph.md
# spi_regfile_periph

Parametrised SPI (mode 0) peripheral that exposes a bank of NUM_REGS writable configuration registers to an external SPI controller, with read-back over CIPO. It succeeds the fixed five-register, write-only peripheral. It adds configurable register count and widths, read transactions, commit-on-deselect with frame-length checking, a write strobe, and an error counter. It sits between the chip pins and the output-enable/PWM control logic, all in the single system clock domain.

## Interface
- NUM_REGS, 5, number of implemented registers (1..2^ADDR_W)
- ADDR_W, 7, address field width
- DATA_W, 8, data field width
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- COPI  in  1  serial data in, asynchronous to clk
- SCLK  in  1  SPI clock, asynchronous to clk, idles low
- nCS  in  1  chip select, active-low, asynchronous to clk
- CIPO  out  1  serial data out
- cipo_oe  out  1  CIPO pad output enable
- reg_out  out  NUM_REGS*DATA_W  register contents; register i at [i*DATA_W +: DATA_W]
- wr_strobe  out  1  one-cycle pulse on each committed write
- wr_addr  out  ADDR_W  address of the last committed write
- err_cnt  out  8  saturating count of discarded frames

## Operation
- Frame: FRAME_W = 1+ADDR_W+DATA_W bits, MSB first. Bit 0 is R/W (1 = write, 0 = read), then the address, then data.
- Synchronisation: COPI, SCLK and nCS each pass through 2 flops. Edges are detected on the synchronised signal against one further delayed flop.
- Frame start (synced nCS fall): bit counter = 0, shift register = 0, frame active.
- On each synced SCLK rise while active:
  - if count < FRAME_W, shift in synced COPI and increment count;
  - else increment count, saturating at FRAME_W+1, and shift nothing.
- Read path:
  - When count reaches 1+ADDR_W and R/W = 0, load the read shift register with reg_out[addr], or 0 if addr ≥ NUM_REGS. Set cipo_oe = 1.
  - CIPO = read shift register MSB. Shift left on each synced SCLK fall after the load.
- Frame end (synced nCS rise):
  - Write commits only if count == FRAME_W, R/W = 1 and addr < NUM_REGS. Commit updates reg_out[addr], pulses wr_strobe and updates wr_addr.
  - Write with addr ≥ NUM_REGS: no register change, no strobe, no error.
  - count != FRAME_W, for any R/W: frame discarded, err_cnt += 1, saturating at 255.
  - In all cases cipo_oe = 0, CIPO = 0, frame inactive.
- SCLK edges with nCS high are ignored.
- Synced nCS fall and SCLK rise in the same cycle: the frame start wins and the SCLK edge is dropped. Controller setup of ≥4 clk between them is required.
- Reset while rst_n low: everything cleared. Sync flops reset to idle values (nCS = 1, SCLK = 0, COPI = 0). A frame already in progress when reset releases is ignored until the next nCS fall.

## Timing
- Reset values: reg_out = 0, wr_strobe = 0, wr_addr = 0, err_cnt = 0, CIPO = 0, cipo_oe = 0.
- SCLK high and low times must each be ≥ 4 clk periods. nCS setup/hold to SCLK must be ≥ 4 clk periods.
- Commit latency: reg_out, wr_strobe and wr_addr update on the 4th clk rising edge after the first edge that samples nCS high at the pin. wr_strobe is high for exactly one cycle.
- CIPO data MSB is valid ≤ 4 clk after the last address SCLK rise, and so before the next SCLK rise given the minimum SCLK low time. Each later bit changes ≤ 4 clk after an SCLK fall.
- Back-to-back frames: nCS high time ≥ 4 clk.

## Structure
- Package spi_regfile_pkg holds:
  - FRAME_W derivation function;
  - RW_WRITE/RW_READ constants;
  - bit-position constants for the R/W, address and data fields.
- Sub-module spi_sync_edge holds the 2-flop synchroniser, delay flop and rise/fall pulse outputs, with a parameter for the reset value. It is instantiated three times.
- Top level holds the counter, the shift registers, the register bank and the commit/error logic.

## Test plan
All scenarios use defaults: NUM_REGS = 5, ADDR_W = 7, DATA_W = 8, SCLK = clk/10.
- Write 0x8055 (addr 0, data 0x55), then 0x84A5 (addr 4) → reg_out[7:0] = 0x55, reg_out[39:32] = 0xA5. Two wr_strobe pulses, each 4 clk after nCS rise. wr_addr = 4.
- Write addr 2 = 0x3C, then read frame 0x0200 → CIPO shifts 0x3C MSB first during bits 8..15. cipo_oe high only from the address-complete point to the nCS rise. reg_out unchanged.
- Read addr 0x7F → CIPO all zeros. Write 0xFF11 (addr 0x7F) → no strobe, reg_out unchanged, err_cnt = 0.
- Frames of 15 bits and 17 bits with write 0x81FF → no register change, err_cnt = 2.
- Assert rst_n for 1 clk after 8 bits of a write frame → all outputs at reset values. Remaining bits and the nCS rise cause no commit. Next full frame commits normally.
- 260 short frames → err_cnt saturates at 255.
